// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes seen by the
// decoder and this block, plus the controller state encoding.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_negate.sv
// Conditional two's-complement of a size-bit word; carry_in lets two instances
// chain into a double-width negation (low half carries into the high half).
module mul_div_negate #(
  parameter int size = 32
) (
  input  logic [size-1:0] value,
  input  logic            neg,
  input  logic            carry_in,
  output logic [size-1:0] result
);

  assign result = neg ? (~value + {{(size-1){1'b0}}, carry_in}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers. One
// shift-add (multiply) or restoring-subtract (divide) step per CALC cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] hi_o,
  output logic [size-1:0] lo_o
);

  localparam int cnt_w = $clog2(size + 1);

  state_e            state, state_nxt;
  logic [cnt_w-1:0]  cnt;
  logic [2*size:0]   acc, acc_step;
  logic [size-1:0]   b_mag_q, src1_q;
  op_e               op_q;
  logic              neg_q, rem_neg_q, div0_q;

  op_e               op_in;
  logic              sgn_in, accept, last_step;
  logic [size-1:0]   a_mag, b_mag;
  logic [size:0]     sum, rem_sh, trial;
  logic [size-1:0]   raw_hi, raw_lo, fix_hi, fix_lo, res_hi, res_lo;

  assign op_in     = op_e'(op_i);
  assign sgn_in    = op_is_signed(op_in);
  assign accept    = start_i && (state != ST_CALC);
  assign last_step = (state == ST_CALC) && (cnt == cnt_w'(1));
  assign busy_o    = (state == ST_CALC);
  assign done_o    = (state == ST_DONE);

  // Operand magnitudes are taken once, at acceptance.
  mul_div_negate #(.size(size)) u_mag_a (
    .value(src1_i), .neg(sgn_in & src1_i[size-1]), .carry_in(1'b1), .result(a_mag)
  );
  mul_div_negate #(.size(size)) u_mag_b (
    .value(src2_i), .neg(sgn_in & src2_i[size-1]), .carry_in(1'b1), .result(b_mag)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_CALC;
      ST_CALC: if (last_step) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start_i ? ST_CALC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sum      = acc[2*size:size] + (acc[0] ? {1'b0, b_mag_q} : '0);
    rem_sh   = acc[2*size-1:size-1];
    trial    = rem_sh - {1'b0, b_mag_q};
    acc_step = {1'b0, sum, acc[size-1:1]};
    if (op_is_div(op_q)) begin
      if (rem_sh >= {1'b0, b_mag_q}) acc_step = {trial, acc[size-2:0], 1'b1};
      else                           acc_step = {rem_sh, acc[size-2:0], 1'b0};
    end
  end

  assign raw_hi = acc_step[2*size-1:size];
  assign raw_lo = acc_step[size-1:0];

  // Sign fix-up: the product negates as one 2*size-bit word, the quotient and
  // remainder negate independently (remainder follows the dividend).
  mul_div_negate #(.size(size)) u_fix_lo (
    .value(raw_lo), .neg(neg_q), .carry_in(1'b1), .result(fix_lo)
  );
  mul_div_negate #(.size(size)) u_fix_hi (
    .value(raw_hi),
    .neg(op_is_div(op_q) ? rem_neg_q : neg_q),
    .carry_in(op_is_div(op_q) ? 1'b1 : (raw_lo == '0)),
    .result(fix_hi)
  );

  always_comb begin
    res_hi = fix_hi;
    res_lo = fix_lo;
    if (op_is_div(op_q) && div0_q) begin
      res_hi = src1_q;
      res_lo = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                cnt <= cnt_w'(size);
      else if (state == ST_CALC) cnt <= cnt - cnt_w'(1);
      if (last_step) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end else if (!accept && state != ST_CALC) begin
        if (hi_we_i) hi_o <= src1_i;
        if (lo_we_i) lo_o <= src1_i;
      end
    end
  end

  // NOTE: working registers have no reset; each start reloads them before they are read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      acc       <= {{(size+1){1'b0}}, a_mag};
      b_mag_q   <= b_mag;
      src1_q    <= src1_i;
      op_q      <= op_in;
      neg_q     <= sgn_in & (src1_i[size-1] ^ src2_i[size-1]);
      rem_neg_q <= sgn_in & src1_i[size-1];
      div0_q    <= (src2_i == '0);
    end else if (state == ST_CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: size, default 32, operand/result width in bits.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start_i  input  1  request a new operation (EX stage, MULT/MULTU/DIV/DIVU decoded).
REQ-005 SHALL have port: op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: src1_i  input  size  multiplicand/dividend.
REQ-007 SHALL have port: src2_i  input  size  multiplier/divisor.
REQ-008 SHALL have port: hi_we_i / lo_we_i  input  1 each  MTHI/MTLO write strobes, data taken from src1_i.
REQ-009 SHALL have port: busy_o  output  1  operation in progress; drives pipeline stall.
REQ-010 SHALL have port: done_o  output  1  one-cycle pulse when hi_o/lo_o first hold a new result.
REQ-011 SHALL have port: hi_o, lo_o  output  size each  HI/LO registers, feed the MFHI/MFLO result-select mux in EX.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; busy_o = (state==CALC); done_o = (state==DONE).
REQ-013 SHALL accept start_i only in IDLE or DONE; on acceptance latch op_i/src1_i/src2_i, load iteration counter with size, go to CALC.
REQ-014 SHALL ignore start_i, hi_we_i, lo_we_i while in CALC.
REQ-015 SHALL remain in CALC for exactly size cycles (one radix-2 shift-add or restoring-subtract step per cycle), then enter DONE.
REQ-016 SHALL update hi_o/lo_o on the edge entering DONE; start sampled at edge 0 -> busy_o high cycles 1..size, done_o high cycle size+1.
REQ-017 SHALL leave DONE to IDLE after one cycle unless a new start_i is accepted.
REQ-018 Multiply: {hi_o,lo_o} = full 2*size-bit product; MULT signed, MULTU unsigned.
REQ-019 Divide: lo_o = quotient, hi_o = remainder; signed ops compute on magnitudes, quotient negated when operand signs differ, remainder takes dividend sign.
REQ-020 Divide by zero: lo_o = all ones, hi_o = src1_i unmodified; same latency, no exception.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): lo_o = 0x80000000, hi_o = 0.
REQ-022 In IDLE/DONE with no accepted start, hi_we_i writes hi_o, lo_we_i writes lo_o on next edge; both may write in the same cycle.
REQ-023 Simultaneous accepted start_i and hi_we_i/lo_we_i: start wins, writes discarded.
REQ-024 hi_o/lo_o SHALL hold previous values throughout CALC.

Reset
REQ-025 On rst_i high: state=IDLE, counter=0, hi_o=0, lo_o=0, busy_o=0, done_o=0, immediately (asynchronous).
REQ-026 Reset during CALC SHALL abort the operation with no partial result visible; first start after release behaves as from power-up.

Structure
REQ-027 Op encodings (MULT/MULTU/DIV/DIVU) and state encodings SHALL live in a shared header of defines used by the decoder and this block.
REQ-028 One sub-module is natural: mul_div_negate (size-bit conditional two's-complement), instanced for operand magnitudes and result sign fix-up.
REQ-029 Datapath SHALL use a single 2*size+1-bit working register shared between multiply and divide.

Verification
REQ-030 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001, done_o exactly cycle 33 after start edge, busy_o high cycles 1..32.
REQ-031 MULT 0xFFFFFFFD(-3)*0x00000005 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
REQ-032 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-033 DIVU 0x00000064/0 -> lo_o=0xFFFFFFFF, hi_o=0x00000064, normal latency.
REQ-034 start_i and lo_we_i pulsed during CALC -> ignored, result of original op delivered; MTLO 0x1234 in IDLE -> lo_o=0x1234 next cycle, hi_o unchanged.
REQ-035 rst_i asserted at CALC cycle 10 -> hi_o=lo_o=0, busy_o=0 immediately; subsequent DIVU 10/3 -> lo_o=3, hi_o=1 at cycle 33.
